// File: rtl/invaders_ram_arbiter.sv
// invaders_ram_arbiter
// Shares the single-port work/video RAM between the 8080 CPU port and the
// video fetcher. After reset the whole RAM is zero-filled, then accesses are
// granted one at a time. Video wins a simultaneous request unless it won the
// previous one. Every access takes three cycles: the grant, the RAM access,
// and the response.
module invaders_ram_arbiter #(
  parameter int ADDR_W         = 13,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [7:0]        o_cpu_rdata,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_ack,
  output logic [7:0]        o_vid_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam state_t            RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  state_t              r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt,   w_clr_cnt_nxt;
  logic                r_last_vid,  w_last_vid_nxt;
  logic                r_gnt_vid,   w_gnt_vid_nxt;
  logic                r_gnt_we,    w_gnt_we_nxt;
  logic [ADDR_W-1:0]   r_ram_addr,  w_ram_addr_nxt;
  logic                r_ram_we,    w_ram_we_nxt;
  logic [7:0]          r_ram_wdata, w_ram_wdata_nxt;
  logic                r_cpu_ack,   w_cpu_ack_nxt;
  logic                r_vid_ack,   w_vid_ack_nxt;
  logic [7:0]          r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]          r_vid_rdata, w_vid_rdata_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                w_grant_vid;

  // Video takes a pending request unless the CPU is also waiting and video won last time.
  assign w_grant_vid = i_vid_req & ~(i_cpu_req & r_last_vid);

  // Next-state and next-output logic for the clear/arbitrate/access sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_last_vid_nxt  = r_last_vid;
    w_gnt_vid_nxt   = r_gnt_vid;
    w_gnt_we_nxt    = r_gnt_we;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_we_nxt    = 1'b0;
    w_ram_wdata_nxt = r_ram_wdata;
    w_cpu_ack_nxt   = 1'b0;
    w_vid_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_vid_rdata_nxt = r_vid_rdata;
    w_busy_nxt      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        // busy drops on the first IDLE edge, together with ram_we.
        w_busy_nxt      = 1'b1;
        w_ram_we_nxt    = 1'b1;
        w_ram_wdata_nxt = 8'h00;
        w_ram_addr_nxt  = r_clr_cnt;
        w_clr_cnt_nxt   = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (r_clr_cnt == ADDR_MAX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (w_grant_vid) begin
          w_ram_addr_nxt = i_vid_addr;
          w_ram_we_nxt   = 1'b0;
          w_gnt_vid_nxt  = 1'b1;
          w_gnt_we_nxt   = 1'b0;
          w_last_vid_nxt = 1'b1;
          w_state_nxt    = S_ACCESS;
        end else if (i_cpu_req) begin
          w_ram_addr_nxt  = i_cpu_addr;
          w_ram_we_nxt    = i_cpu_we;
          w_ram_wdata_nxt = i_cpu_wdata;
          w_gnt_vid_nxt   = 1'b0;
          w_gnt_we_nxt    = i_cpu_we;
          w_last_vid_nxt  = 1'b0;
          w_state_nxt     = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        // The RAM samples address/we on this edge; q is valid in RESP.
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (r_gnt_vid) begin
          w_vid_ack_nxt   = 1'b1;
          w_vid_rdata_nxt = i_ram_rdata;
        end else begin
          w_cpu_ack_nxt = 1'b1;
          if (!r_gnt_we) begin
            w_cpu_rdata_nxt = i_ram_rdata;
          end else begin
            w_cpu_rdata_nxt = r_cpu_rdata;
          end
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
  end

  // State and output registers; reset aborts any access and restarts the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RST_STATE;
      r_clr_cnt   <= '0;
      r_last_vid  <= 1'b0;
      r_gnt_vid   <= 1'b0;
      r_gnt_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'h00;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_rdata <= 8'h00;
      r_vid_rdata <= 8'h00;
      r_busy      <= CLEAR_ON_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_last_vid  <= w_last_vid_nxt;
      r_gnt_vid   <= w_gnt_vid_nxt;
      r_gnt_we    <= w_gnt_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_vid_ack   <= w_vid_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_vid_rdata <= w_vid_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_vid_ack   = r_vid_ack;
  assign o_vid_rdata = r_vid_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// Testbench for invaders_ram_arbiter: a registered-q RAM model, a
// transaction-level reference model, a per-cycle compare process, and
// directed plus randomized stimulus.
module tb_invaders_ram_arbiter;
  localparam int ADDR_W    = 13;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CLEAR_END = DEPTH + 1;   // edge number of the first IDLE edge

  logic              clk, rst;
  logic              cpu_req, cpu_we, vid_req;
  logic [ADDR_W-1:0] cpu_addr, vid_addr;
  logic [7:0]        cpu_wdata;
  logic              w_cpu_ack, w_vid_ack, w_ram_we, w_busy;
  logic [7:0]        w_cpu_rdata, w_vid_rdata, w_ram_wdata, ram_q;
  logic [ADDR_W-1:0] w_ram_addr;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  invaders_ram_arbiter #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(w_cpu_ack), .o_cpu_rdata(w_cpu_rdata),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr),
    .o_vid_ack(w_vid_ack), .o_vid_rdata(w_vid_rdata),
    .o_ram_addr(w_ram_addr), .o_ram_we(w_ram_we), .o_ram_wdata(w_ram_wdata),
    .i_ram_rdata(ram_q), .o_busy(w_busy)
  );

  // Single-port RAM with registered q (read-before-write), optional A5 preload.
  logic [7:0] ram_mem [DEPTH];
  logic       preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'hA5;
    end else if (w_ram_we) begin
      ram_mem[w_ram_addr] <= w_ram_wdata;
    end
    ram_q <= ram_mem[w_ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: edge counter, access-slot timing and RAM contents.
  int         e, free_at, cpu_ack_at, vid_ack_at, we_at;
  bit         m_last_vid, cpu_pend_rd;
  logic [7:0] pend_cpu, pend_vid, exp_cpu_rdata, exp_vid_rdata;
  logic [7:0] ref_mem [DEPTH];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e = 0; free_at = 0; cpu_ack_at = -1; vid_ack_at = -1; we_at = -1;
        m_last_vid = 1'b0; cpu_pend_rd = 1'b0;
        exp_cpu_rdata = 8'h00; exp_vid_rdata = 8'h00;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;  // what the clear will leave
      end else begin
        e++;
        if (e == cpu_ack_at && cpu_pend_rd) exp_cpu_rdata = pend_cpu;
        if (e == vid_ack_at) exp_vid_rdata = pend_vid;
        if (e >= CLEAR_END && e >= free_at && (cpu_req || vid_req)) begin
          if (vid_req && !(cpu_req && m_last_vid)) begin
            m_last_vid = 1'b1;
            vid_ack_at = e + 2;
            pend_vid   = ref_mem[vid_addr];
          end else begin
            m_last_vid  = 1'b0;
            cpu_ack_at  = e + 2;
            cpu_pend_rd = !cpu_we;
            if (cpu_we) begin
              ref_mem[cpu_addr] = cpu_wdata;
              we_at = e;
            end else begin
              pend_cpu = ref_mem[cpu_addr];
            end
          end
          free_at = e + 3;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", {31'd0, w_busy}, {31'd0, e < CLEAR_END});
      chk("ram_we", {31'd0, w_ram_we}, {31'd0, (e >= 1 && e < CLEAR_END) || (e == we_at)});
      if (e >= 1 && e < CLEAR_END) begin
        chk("clr_addr", {19'd0, w_ram_addr}, e - 1);
        chk("clr_wdata", {24'd0, w_ram_wdata}, 32'd0);
      end
      chk("cpu_ack", {31'd0, w_cpu_ack}, {31'd0, e == cpu_ack_at});
      chk("vid_ack", {31'd0, w_vid_ack}, {31'd0, e == vid_ack_at});
      chk("cpu_rdata", {24'd0, w_cpu_rdata}, {24'd0, exp_cpu_rdata});
      chk("vid_rdata", {24'd0, w_vid_rdata}, {24'd0, exp_vid_rdata});
    end
  end

  // Wait (bounded) for an ack on one port, drop that port's request, report the edge.
  task automatic wait_ack(input bit is_vid, input string nm, output int edge_no);
    bit found = 1'b0;
    edge_no = -1;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (is_vid ? w_vid_ack : w_cpu_ack) begin
        found = 1'b1;
        edge_no = e;
        if (is_vid) vid_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    if (!found) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Requester traffic; cont=1 keeps both ports permanently requesting.
  task automatic run_traffic(input int ncyc, input int pct, input bit cont,
                             output int n_acks, output int max_wait, output int alt_viol);
    int cpu_t = 0, vid_t = 0, prev = -1;
    n_acks = 0; max_wait = 0; alt_viol = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (cpu_req && w_cpu_ack) begin
        n_acks++;
        if (e - cpu_t > max_wait) max_wait = e - cpu_t;
        if (prev == 0) alt_viol++;
        prev = 0; cpu_req = 1'b0;
      end
      if (vid_req && w_vid_ack) begin
        n_acks++;
        if (e - vid_t > max_wait) max_wait = e - vid_t;
        if (prev == 1) alt_viol++;
        prev = 1; vid_req = 1'b0;
      end
      if (!cpu_req && (cont || $urandom_range(99) < pct)) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
        cpu_addr = 13'h0400 + 13'($urandom_range(15));
        cpu_wdata = 8'($urandom); cpu_t = e;
      end
      if (!vid_req && (cont || $urandom_range(99) < pct)) begin
        vid_req = 1'b1; vid_addr = 13'h0400 + 13'($urandom_range(15)); vid_t = e;
      end
    end
    for (int n = 0; n < 20 && (cpu_req || vid_req); n++) begin
      @(negedge clk);
      if (w_cpu_ack) cpu_req = 1'b0;
      if (w_vid_ack) vid_req = 1'b0;
    end
    chk("drain", {30'd0, cpu_req, vid_req}, 32'd0);
  endtask

  int busy_we, fall, nz, ack_e, t, v_e, c_e, n_acks, max_wait, alt_viol;
  bit seen;

  initial begin
    rst = 1'b1; preload = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
    repeat (2) @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk("ram_preloaded", {24'd0, ram_mem[13'h0400]}, 32'h000000A5);
    #2 rst = 1'b0;

    // Clear sequence; a CPU write is posted while busy and must wait for the clear.
    busy_we = 0; fall = -1;
    for (int i = 0; i < CLEAR_END + 20 && fall < 0; i++) begin
      @(negedge clk);
      if (w_busy && w_ram_we) busy_we++;
      if (!w_busy) fall = e;
      if (i == 100) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = 8'h3C;
      end
    end
    chk("busy_we_cycles", busy_we, 32'd8192);
    chk("busy_fall_edge", fall, 32'd8193);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== 8'h00) nz++;
    chk("ram_cleared", nz, 32'd0);

    // Write then read back 0x0400.
    wait_ack(1'b0, "wr", ack_e);
    chk("wr_ack_edge", ack_e, 32'd8195);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
    wait_ack(1'b0, "rd", ack_e);
    chk("rd_ack_edge", ack_e, 32'd8198);
    chk("rd_data", {24'd0, w_cpu_rdata}, 32'h0000003C);

    // Simultaneous requests with last_vid=0: video first.
    @(negedge clk);
    t = e;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
    vid_req = 1'b1; vid_addr = 13'h0400;
    wait_ack(1'b1, "sim_vid", v_e);
    wait_ack(1'b0, "sim_cpu", c_e);
    chk("sim_vid_ack", v_e, t + 3);
    chk("sim_cpu_ack", c_e, t + 6);
    chk("sim_vid_data", {24'd0, w_vid_rdata}, 32'h0000003C);

    // Both ports continuously requesting.
    run_traffic(32, 0, 1'b1, n_acks, max_wait, alt_viol);
    chk("cont_acks_ge10", {31'd0, n_acks >= 10}, 32'd1);
    chk("cont_alternate", alt_viol, 32'd0);
    chk("cont_wait_le6", {31'd0, max_wait <= 6}, 32'd1);

    // Randomized traffic.
    run_traffic(1500, 40, 1'b0, n_acks, max_wait, alt_viol);
    chk("rand_progress", {31'd0, n_acks > 100}, 32'd1);

    // Reset during ACCESS of a CPU write to the last address.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h5A;
    @(negedge clk);
    chk("abort_access_we", {31'd0, w_ram_we}, 32'd1);
    chk("abort_access_addr", {19'd0, w_ram_addr}, 32'h00001FFF);
    #2 rst = 1'b1; cpu_req = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= w_cpu_ack;
    chk("abort_busy", {31'd0, w_busy}, 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    seen |= w_cpu_ack;
    chk("restart_addr", {19'd0, w_ram_addr}, 32'd0);
    fall = -1;
    for (int i = 0; i < CLEAR_END + 20 && fall < 0; i++) begin
      @(negedge clk);
      seen |= w_cpu_ack;
      if (!w_busy) fall = e;
    end
    chk("abort_no_ack", {31'd0, seen}, 32'd0);
    chk("abort_busy_fall", fall, 32'd8193);
    chk("ram_1fff_cleared", {24'd0, ram_mem[13'h1FFF]}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
    wait_ack(1'b0, "rd_1fff", ack_e);
    chk("rd_1fff_data", {24'd0, w_cpu_rdata}, 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
